// File: rtl/cdb_arbiter.sv
// Completion arbiter in front of the CDB mux: latches one request per FU and grants one per cycle.
// Round-robin by default; define CDB_FIXED_PRIO_EN for lowest-index-first priority.
module cdb_arbiter #(
  parameter int NUM_FU    = 5,
  parameter int ROB_TAG_W = 5
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [NUM_FU-1:0]                   fu_done,
  input  logic [NUM_FU-1:0][ROB_TAG_W-1:0]    fu_rob_tag,
  output logic [NUM_FU-1:0]                   fu_busy,
  output logic                                select_flag,
  output logic [2:0]                          select,
  output logic [ROB_TAG_W-1:0]                out_ROB_tag
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Handshake: an FU may assert fu_done[i] only while fu_busy[i] is low; the
  // request is then owned by the arbiter until broadcast (or flush/reset).
  logic [NUM_FU-1:0]    r_pending;
  logic [ROB_TAG_W-1:0] r_pend_tag [NUM_FU];
  logic                 r_select_flag;
  logic [2:0]           r_select;
  logic [ROB_TAG_W-1:0] r_out_tag;

  logic [NUM_FU-1:0]    w_grant;
  logic [NUM_FU-1:0]    w_capture;
  logic [2:0]           w_winner;
  logic [IDX_W-1:0]     w_winner_idx;
  logic                 w_any;

  function automatic logic [2:0] lowest_set(input logic [NUM_FU-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    w_any    = |r_pending;
    w_winner = lowest_set(r_pending);
  end
`else
  logic [2:0]        r_rr_ptr;
  logic [NUM_FU-1:0] w_ge_mask;
  logic [NUM_FU-1:0] w_upper;
  logic [2:0]        w_rr_next;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    w_ge_mask = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_ge_mask[i] = (3'(i) >= r_rr_ptr);
    end
    w_upper  = r_pending & w_ge_mask;
    w_any    = |r_pending;
    w_winner = (|w_upper) ? lowest_set(w_upper) : lowest_set(r_pending);
  end

  always_comb begin
    w_rr_next = (w_winner == 3'(NUM_FU - 1)) ? 3'd0 : w_winner + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (!flush && w_any) begin
      r_rr_ptr <= w_rr_next;
    end
  end
`endif

  always_comb begin
    w_winner_idx = w_winner[IDX_W-1:0];
    w_grant      = '0;
    if (w_any) begin
      w_grant[w_winner_idx] = 1'b1;
    end
  end

  // The granted slot frees this cycle so its FU can hand over the next result immediately.
  assign fu_busy   = r_pending & ~w_grant;
  assign w_capture = fu_done & ~fu_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending     <= '0;
      r_select_flag <= 1'b0;
      r_select      <= '0;
      r_out_tag     <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_pend_tag[i] <= '0;
      end
    end else if (flush) begin
      r_pending     <= '0;
      r_select_flag <= 1'b0;
    end else begin
      r_pending     <= (r_pending & ~w_grant) | w_capture;
      r_select_flag <= w_any;
      if (w_any) begin
        r_select  <= w_winner;
        r_out_tag <= r_pend_tag[w_winner_idx];
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_capture[i]) r_pend_tag[i] <= fu_rob_tag[i];
      end
    end
  end

  assign select_flag = r_select_flag;
  assign select      = r_select;
  assign out_ROB_tag = r_out_tag;

  a_no_done_while_busy: assert property (
    @(posedge clock) disable iff (reset) ((fu_done & fu_busy) == '0)
  );

endmodule
